keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner with per-key debounce and a buffered key-event interface. It drives active-low rows one at a time and samples active-low columns through a synchroniser. Each key has a debounced state, and every debounced press or release is pushed as an event into a small FIFO read with a valid/ready handshake. It sits between the keypad pins and the CPU-side peripheral register block, and runs entirely in the `clk` domain; no derived clocks are used.

## Interface
- `ROWS`, default 4: number of driven rows, ≥2.
- `COLS`, default 4: number of sensed columns, ≥1.
- `CLK_DIV`, default 5000: clk cycles per row slot; must be ≥ COLS+4.
- `DEBOUNCE`, default 4: consecutive differing frame samples required to flip a key's state; ≥1.
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, ≥2.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `col_n` in COLS: raw column inputs, low = pressed, asynchronous.
- `row_n` out ROWS: row drive, exactly one bit low.
- `key_state` out ROWS*COLS: debounced state, 1 = pressed; bit index = row*COLS+col.
- `ev_valid` out 1: FIFO head holds an event.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_code` out clog2(ROWS*COLS): key index of the head event.
- `ev_press` out 1: 1 = press, 0 = release.
- `ev_overflow` out 1: sticky; set when an event was dropped.
- `ovf_clr` in 1: single-cycle clear of `ev_overflow`.

## Operation
- Reset values:
  - `row_n` has bit0 low and all other bits high.
  - Row index is 0 and the divider count is 0.
  - Synchroniser flops are all ones.
  - `key_state`, all debounce counters, FIFO pointers, `ev_valid` and `ev_overflow` are 0.
  - `ev_code` and `ev_press` are 0.
- Divider: `cnt` counts 0..CLK_DIV-1 and wraps. The cycle with `cnt==CLK_DIV-1` is the sample tick.
- At the sample tick:
  - The synchronised `~col_n` is latched into the sample register `smp[COLS-1:0]`.
  - On the next cycle the row index advances (ROWS-1 wraps to 0) and `row_n` updates.
  - A frame is ROWS*CLK_DIV cycles.
- Evaluation phase: over the COLS cycles following the tick, column c is evaluated in cycle tick+1+c for the row just sampled. Each evaluation handles one key:
  - If `smp[c]` equals the key's state, its counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE, the state flips, the counter clears, and a push is requested with code = row*COLS+c and press = new state.
- At most one push occurs per cycle, so no arbitration is needed.
- FIFO:
  - A pop occurs when `ev_valid && ev_ready`.
  - Fullness is judged on the pre-pop count. A push while full is dropped even if a pop happens in the same cycle, and it sets `ev_overflow`.
  - `key_state` updates regardless of drops.
- `ovf_clr` clears `ev_overflow` unless a drop occurs in the same cycle; the drop wins and the flag stays set.
- Mid-operation reset returns every output to its reset value on the next edge. Queued events are discarded.

## Timing
- Synchroniser is 2 flops, so the column settle margin is CLK_DIV-3 cycles before the sample.
- Push latency: a push decided in cycle tick+1+c is visible as `ev_valid=1` (first-word show-ahead) at cycle tick+2+c when the FIFO was empty.
- `key_state` changes in the same cycle as `ev_valid` rises.
- Press latency: DEBOUNCE frames after the first pressed sample. A stable press seen at frame k flips state at frame k+DEBOUNCE-1.
- Events are delivered in push order. `ev_code` and `ev_press` are stable while `ev_valid && !ev_ready`.
- Frame-to-frame: each key is sampled exactly once per frame, at a fixed offset within its row slot.

## Structure
- Package `keypad_pkg` holds the shared definitions:
  - Event width constant, derived as clog2(ROWS*COLS)+1.
  - Key-index computation function.
  - Debounce counter width, derived as clog2(DEBOUNCE+1).
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH):
  - Ports: push, pop, full, empty, data.
  - Same clk/rstn.
  - Reusable elsewhere in the peripheral set.
- The divider, row rotation, synchroniser, debounce array and overflow flag are implemented inline in `keypad_scanner`.

## Test plan
All scenarios use ROWS=4, COLS=4, CLK_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4 unless noted.
1. Rotation after reset: `row_n` sequence is 1110 → 1101 → 1011 → 0111 → 1110, each row held 8 cycles. `ev_valid` stays 0 with no keys pressed.
2. Single press/release on row 1, col 2: exactly one event with code 6, press=1, after 3 frames. Release gives code 6, press=0. `key_state[6]` tracks the event.
3. Bounce: toggle key 6 so it is pressed for 2 frames, then released. Required: no event and `key_state` remains 0.
4. Same-row simultaneous press on row 2, cols 0 and 3 in the same frame: two events, code 8 then 11, each press=1, arriving 3 cycles apart when `ev_ready=1`.
5. Overflow: hold `ev_ready=0` and generate 5 press events. Required:
   - 4 events are queued, the 5th is dropped, and `ev_overflow=1`.
   - `key_state` shows all 5 keys pressed.
   - `ovf_clr` in the same cycle as a 6th drop leaves the flag at 1; a later `ovf_clr` alone clears it.
6. Reset mid-operation: assert `rstn=0` for 1 cycle with 2 events queued. Required: `ev_valid=0`, `key_state=0`, `row_n=1110`, and held keys are re-reported as press events 3 frames later.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: derived widths and key numbering.
package keypad_pkg;

  localparam int SYNC_STAGES = 2;

  // Event word = key index plus one press/release bit.
  function automatic int ev_width(input int rows, input int cols);
    return $clog2(rows * cols) + 1;
  endfunction

  function automatic int dbc_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

  function automatic int key_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_scanner_fifo.sv
// Small synchronous FIFO with show-ahead read data; pushes while full are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row rotation, column synchroniser, per-key debounce
// and a buffered press/release event queue with a sticky overflow flag.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int CLK_DIV    = 5000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [COLS-1:0]               col_n,
  output logic [ROWS-1:0]               row_n,
  output logic [ROWS*COLS-1:0]          key_state,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(ROWS*COLS)-1:0]  ev_code,
  output logic                          ev_press,
  output logic                          ev_overflow,
  input  logic                          ovf_clr
);

  localparam int N     = ROWS * COLS;
  localparam int KEY_W = $clog2(N);
  localparam int EV_W  = ev_width(ROWS, COLS);
  localparam int DBC_W = dbc_width(DEBOUNCE);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [ROW_W-1:0] row_idx;
  logic [ROW_W-1:0] row_nxt;

  logic [COLS-1:0]  col_p0;
  logic [COLS-1:0]  col_p1;
  logic [COLS-1:0]  smp;
  logic [ROW_W-1:0] smp_row;
  logic             eval_vld;

  logic [COL_W-1:0] col_eval;
  logic [KEY_W-1:0] key_idx;
  logic             cur_state;
  logic [DBC_W-1:0] cur_cnt;
  logic [DBC_W-1:0] dbc_nxt;
  logic             flip;
  logic             push_req;
  logic [DBC_W-1:0] dbc [N];

  logic [EV_W-1:0]  push_data;
  logic [EV_W-1:0]  head_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  // Slot divider and row rotation
  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  always_comb begin
    row_nxt = (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt     <= '0;
      row_idx <= '0;
      row_n   <= ~ROWS'(1);
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        row_idx <= row_nxt;
        row_n   <= ~(ROWS'(1) << row_nxt);
      end
    end
  end

  // Stage p0/p1: two-flop column synchroniser, idle level is released (high)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      col_p0 <= '1;
      col_p1 <= '1;
    end else begin
      col_p0 <= col_n;
      col_p1 <= col_p0;
    end
  end

  // Stage p2: sample register, captured once per row slot
  always_ff @(posedge clk) begin
    if (tick) begin
      smp     <= ~col_p1;
      smp_row <= row_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      eval_vld <= 1'b0;
    end else if (tick) begin
      eval_vld <= 1'b1;
    end else if (eval_vld && cnt == CNT_W'(COLS - 1)) begin
      eval_vld <= 1'b0;
    end
  end

  // Evaluation: the free-running count picks one column per cycle after the tick
  assign col_eval  = cnt[COL_W-1:0];
  assign key_idx   = KEY_W'(key_index(int'(smp_row), int'(col_eval), COLS));
  assign cur_state = key_state[key_idx];
  assign cur_cnt   = dbc[key_idx];

  always_comb begin
    dbc_nxt  = cur_cnt;
    flip     = 1'b0;
    push_req = 1'b0;
    if (eval_vld) begin
      if (smp[col_eval] == cur_state) begin
        dbc_nxt = '0;
      end else if (cur_cnt == DBC_W'(DEBOUNCE - 1)) begin
        dbc_nxt  = '0;
        flip     = 1'b1;
        push_req = 1'b1;
      end else begin
        dbc_nxt = cur_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      key_state <= '0;
      for (int k = 0; k < N; k++) dbc[k] <= '0;
    end else if (eval_vld) begin
      dbc[key_idx] <= dbc_nxt;
      if (flip) key_state[key_idx] <= ~cur_state;
    end
  end

  // Event queue; a push against a full queue is lost and latched as overflow
  assign push_data = {key_idx, ~cur_state};
  assign pop       = ev_valid && ev_ready;
  assign drop      = push_req && fifo_full;

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_req),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = head_data[EV_W-1:1];
  assign ev_press = head_data[0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ev_overflow <= 1'b0;
    end else if (drop) begin
      ev_overflow <= 1'b1;
    end else if (ovf_clr) begin
      ev_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

  localparam int ROWS = 4, COLS = 4, CLK_DIV = 8, DEBOUNCE = 3, FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] key_state;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [3:0]  ev_code;
  logic        ev_press;
  logic        ev_overflow;
  logic        ovf_clr = 1'b0;
  logic [15:0] pressed = '0;

  int n_vec = 0;
  int n_miss = 0;
  int cyc;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .col_n(col_n), .row_n(row_n), .key_state(key_state),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_press(ev_press),
    .ev_overflow(ev_overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the DUT slot count phase
  always @(posedge clk) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // A pressed key shorts its column low while its row is driven low
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_n[r] && pressed[r*COLS+c]) col_n[c] = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (ev_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (row_n !== 4'b1110) begin n_miss++; $display("FAIL reset_row_n: got %b want 1110", row_n); end
    n_vec++;
    if (key_state !== 16'h0) begin n_miss++; $display("FAIL reset_key_state: got %h want 0000", key_state); end
    n_vec++;
    if ({ev_valid, ev_code, ev_press, ev_overflow} !== 7'b0) begin
      n_miss++;
      $display("FAIL reset_ev: got v=%b code=%0d p=%b ovf=%b want all 0", ev_valid, ev_code, ev_press, ev_overflow);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    for (int i = 0; i < 40; i++) begin
      exp = 4'b0001 << ((i / 8) % 4);
      exp = ~exp;
      n_vec++;
      if (row_n !== exp) begin n_miss++; $display("FAIL rotation[%0d]: got %b want %b", i, row_n, exp); end
      n_vec++;
      if (ev_valid !== 1'b0) begin n_miss++; $display("FAIL idle_valid[%0d]: got %b want 0", i, ev_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_press();
    bit ok;
    int t0;
    pressed[6] = 1'b1;
    t0 = cyc;
    wait_valid(200, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL press_timeout: got no event want event"); end
    n_vec++;
    if (cyc - t0 < 68 || cyc - t0 > 104) begin n_miss++; $display("FAIL press_latency: got %0d want 68..104", cyc - t0); end
    n_vec++;
    if ({ev_code, ev_press} !== {4'd6, 1'b1}) begin n_miss++; $display("FAIL press_event: got code=%0d p=%b want 6/1", ev_code, ev_press); end
    n_vec++;
    if (key_state !== 16'h0040) begin n_miss++; $display("FAIL press_state: got %h want 0040", key_state); end
    repeat (5) @(negedge clk);
    n_vec++;
    if ({ev_valid, ev_code, ev_press} !== {1'b1, 4'd6, 1'b1}) begin
      n_miss++; $display("FAIL hold_stable: got v=%b code=%0d p=%b want 1/6/1", ev_valid, ev_code, ev_press);
    end
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    n_vec++;
    if (ev_valid !== 1'b0) begin n_miss++; $display("FAIL pop_empty: got %b want 0", ev_valid); end
    pressed[6] = 1'b0;
    wait_valid(200, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL release_timeout: got no event want event"); end
    n_vec++;
    if ({ev_code, ev_press} !== {4'd6, 1'b0}) begin n_miss++; $display("FAIL release_event: got code=%0d p=%b want 6/0", ev_code, ev_press); end
    n_vec++;
    if (key_state !== 16'h0000) begin n_miss++; $display("FAIL release_state: got %h want 0000", key_state); end
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic test_bounce();
    pressed[6] = 1'b1;
    repeat (64) @(negedge clk);
    pressed[6] = 1'b0;
    repeat (128) @(negedge clk);
    n_vec++;
    if (ev_valid !== 1'b0) begin n_miss++; $display("FAIL bounce_valid: got %b want 0", ev_valid); end
    n_vec++;
    if (key_state !== 16'h0000) begin n_miss++; $display("FAIL bounce_state: got %h want 0000", key_state); end
  endtask

  task automatic test_same_row();
    bit ok;
    int t1;
    ev_ready = 1'b1;
    pressed[8] = 1'b1;
    pressed[11] = 1'b1;
    wait_valid(200, ok);
    t1 = cyc;
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL row_first_timeout: got no event want event"); end
    n_vec++;
    if ({ev_code, ev_press} !== {4'd8, 1'b1}) begin n_miss++; $display("FAIL row_first: got code=%0d p=%b want 8/1", ev_code, ev_press); end
    @(negedge clk);
    wait_valid(10, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL row_second_timeout: got no event want event"); end
    n_vec++;
    if (cyc - t1 != 3) begin n_miss++; $display("FAIL row_spacing: got %0d want 3", cyc - t1); end
    n_vec++;
    if ({ev_code, ev_press} !== {4'd11, 1'b1}) begin n_miss++; $display("FAIL row_second: got code=%0d p=%b want 11/1", ev_code, ev_press); end
    pressed = '0;
    repeat (192) @(negedge clk);
    n_vec++;
    if ({ev_valid, key_state} !== 17'h0) begin n_miss++; $display("FAIL row_cleanup: got v=%b ks=%h want 0/0000", ev_valid, key_state); end
    ev_ready = 1'b0;
  endtask

  task automatic test_overflow();
    bit done;
    while (cyc % 32 != 0) @(negedge clk);
    pressed[4:0] = 5'b11111;
    repeat (192) @(negedge clk);
    n_vec++;
    if (ev_overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_set: got %b want 1", ev_overflow); end
    n_vec++;
    if (key_state !== 16'h001F) begin n_miss++; $display("FAIL ovf_state: got %h want 001f", key_state); end
    pressed[5] = 1'b1;
    done = 1'b0;
    for (int f = 0; f < 6 && !done; f++) begin
      while (cyc % 32 != 17) @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      if (key_state[5]) begin
        done = 1'b1;
        n_vec++;
        if (ev_overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_drop_wins: got %b want 1", ev_overflow); end
      end else begin
        n_vec++;
        if (ev_overflow !== 1'b0) begin n_miss++; $display("FAIL ovf_clr_frame%0d: got %b want 0", f, ev_overflow); end
      end
    end
    n_vec++;
    if (!done) begin n_miss++; $display("FAIL ovf_sixth_timeout: got no flip want key 5 pressed"); end
    n_vec++;
    if (key_state !== 16'h003F) begin n_miss++; $display("FAIL ovf_state6: got %h want 003f", key_state); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({ev_valid, ev_code, ev_press} !== {1'b1, 4'(k), 1'b1}) begin
        n_miss++; $display("FAIL ovf_drain[%0d]: got v=%b code=%0d p=%b want 1/%0d/1", k, ev_valid, ev_code, ev_press, k);
      end
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
    n_vec++;
    if (ev_valid !== 1'b0) begin n_miss++; $display("FAIL ovf_drained: got %b want 0", ev_valid); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_vec++;
    if (ev_overflow !== 1'b0) begin n_miss++; $display("FAIL ovf_clear: got %b want 0", ev_overflow); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pressed = '0;
    ev_ready = 1'b1;
    repeat (192) @(negedge clk);
    ev_ready = 1'b0;
    pressed[9] = 1'b1;
    pressed[10] = 1'b1;
    repeat (192) @(negedge clk);
    n_vec++;
    if ({ev_valid, ev_code, ev_press} !== {1'b1, 4'd9, 1'b1}) begin
      n_miss++; $display("FAIL mid_queued: got v=%b code=%0d p=%b want 1/9/1", ev_valid, ev_code, ev_press);
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_vec++;
    if ({ev_valid, key_state, row_n, ev_overflow} !== {1'b0, 16'h0, 4'b1110, 1'b0}) begin
      n_miss++; $display("FAIL mid_reset: got v=%b ks=%h row=%b ovf=%b want 0/0000/1110/0", ev_valid, key_state, row_n, ev_overflow);
    end
    ev_ready = 1'b1;
    wait_valid(200, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL mid_repress_timeout: got no event want event"); end
    n_vec++;
    if ({cyc, ev_code, ev_press} !== {32'd90, 4'd9, 1'b1}) begin
      n_miss++; $display("FAIL mid_repress9: got cyc=%0d code=%0d p=%b want 90/9/1", cyc, ev_code, ev_press);
    end
    @(negedge clk);
    n_vec++;
    if ({ev_valid, cyc, ev_code, ev_press} !== {1'b1, 32'd91, 4'd10, 1'b1}) begin
      n_miss++; $display("FAIL mid_repress10: got v=%b cyc=%0d code=%0d p=%b want 1/91/10/1", ev_valid, cyc, ev_code, ev_press);
    end
    n_vec++;
    if (key_state !== 16'h0600) begin n_miss++; $display("FAIL mid_state: got %h want 0600", key_state); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single_press();
    test_bounce();
    test_same_row();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
